// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, types and helpers for the decryption datapath.
//   AES_NB      - columns per state (4)
//   AES_BYTE_W  - bits per byte (8)
//   AES_POLY    - low byte of the GF(2^8) reduction polynomial x^8+x^4+x^3+x+1
//   aes_byte_t / aes_col_t / aes_state_t - byte, 4-byte column, 4-column state
//     (column c occupies bits [32c+31:32c], row r of a column bits [8r+7:8r])
//   imc_fsm_e   - InvMixColumns engine FSM states
//   xtime()     - multiply by x (0x02) in GF(2^8)
package aes_pkg;

    localparam int unsigned AES_NB     = 4;
    localparam int unsigned AES_BYTE_W = 8;
    localparam logic [7:0]  AES_POLY   = 8'h1B;

    typedef logic [AES_BYTE_W-1:0] aes_byte_t;
    typedef aes_byte_t [3:0]       aes_col_t;
    typedef aes_col_t [AES_NB-1:0] aes_state_t;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } imc_fsm_e;

    function automatic aes_byte_t xtime(input aes_byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/inv_mix_columns_seq_if.sv
// inv_mix_columns_seq_if: valid/ready bus of the InvMixColumns engine.
//   in_valid/in_ready/in_state    - input state handshake (producer -> engine)
//   out_valid/out_ready/out_state - result handshake (engine -> consumer)
//   busy                          - engine is transforming columns
// Modports: master = environment around the engine, slave = the engine itself.
interface inv_mix_columns_seq_if;
    import aes_pkg::*;

    logic       in_valid;
    logic       in_ready;
    aes_state_t in_state;
    logic       out_valid;
    logic       out_ready;
    aes_state_t out_state;
    logic       busy;

    modport master (
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_state, busy
    );

    modport slave (
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_state, busy
    );

endinterface

// File: rtl/inv_mix_column.sv
// inv_mix_column: combinational AES InvMixColumns on a single column.
//   col_i - input column, rows a0..a3
//   col_o - output column, b_r = 0e.a_r ^ 0b.a_r+1 ^ 0d.a_r+2 ^ 09.a_r+3 (row indices mod 4)
// Constant multiplies are xtime chains only; no general GF multiplier.
module inv_mix_column
    import aes_pkg::*;
(
    input  aes_col_t col_i,
    output aes_col_t col_o
);

    aes_col_t x2, x4, x8;
    aes_col_t m9, mb, md, me;

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            x2[r] = xtime(col_i[r]);
            x4[r] = xtime(x2[r]);
            x8[r] = xtime(x4[r]);
            m9[r] = x8[r] ^ col_i[r];
            mb[r] = x8[r] ^ x2[r] ^ col_i[r];
            md[r] = x8[r] ^ x4[r] ^ col_i[r];
            me[r] = x8[r] ^ x4[r] ^ x2[r];
        end
    end

    assign col_o[0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
    assign col_o[1] = me[1] ^ mb[2] ^ md[3] ^ m9[0];
    assign col_o[2] = me[2] ^ mb[3] ^ md[0] ^ m9[1];
    assign col_o[3] = me[3] ^ mb[0] ^ md[1] ^ m9[2];

endmodule

// File: rtl/inv_mix_columns_seq.sv
// inv_mix_columns_seq: iterative AES InvMixColumns engine.
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset; discards any state in flight
//   bus_io - inv_mix_columns_seq_if.slave: in_valid/in_ready/in_state,
//            out_valid/out_ready/out_state, busy
// Default build: one column per cycle, 4-cycle latency, one state per 6 cycles.
// INV_MIX_COLUMNS_UNROLL_EN: four column units in parallel, 1-cycle latency.
// All handshake outputs are registered, so there is no in_valid->in_ready or
// out_ready->out_valid combinational path.
module inv_mix_columns_seq
    import aes_pkg::*;
(
    input logic                   clk,
    input logic                   rst_n,
    inv_mix_columns_seq_if.slave  bus_io
);

    imc_fsm_e   fsm_q, fsm_d;
    aes_state_t data_q, data_d;
    logic       in_ready_q, in_ready_d;
    logic       out_valid_q, out_valid_d;
    logic       busy_q, busy_d;

`ifdef INV_MIX_COLUMNS_UNROLL_EN
    aes_state_t mixed;

    for (genvar c = 0; c < AES_NB; c++) begin : g_col
        inv_mix_column u_col (
            .col_i (data_q[c]),
            .col_o (mixed[c])
        );
    end
`else
    logic [1:0] col_cnt_q, col_cnt_d;
    aes_col_t   col_in, col_out;

    assign col_in = data_q[col_cnt_q];

    inv_mix_column u_col (
        .col_i (col_in),
        .col_o (col_out)
    );
`endif

    always_comb begin
        fsm_d  = fsm_q;
        data_d = data_q;
`ifndef INV_MIX_COLUMNS_UNROLL_EN
        col_cnt_d = col_cnt_q;
`endif
        unique case (fsm_q)
            StIdle: begin
                if (bus_io.in_valid) begin
                    data_d = bus_io.in_state;
`ifndef INV_MIX_COLUMNS_UNROLL_EN
                    col_cnt_d = 2'd0;
`endif
                    fsm_d = StBusy;
                end
            end
            StBusy: begin
`ifdef INV_MIX_COLUMNS_UNROLL_EN
                data_d = mixed;
                fsm_d  = StDone;
`else
                data_d[col_cnt_q] = col_out;
                col_cnt_d         = col_cnt_q + 2'd1;  // wraps to 0 after column 3
                if (col_cnt_q == 2'd3) begin
                    fsm_d = StDone;
                end
`endif
            end
            StDone: begin
                if (bus_io.out_ready) begin
                    fsm_d = StIdle;
                end
            end
            default: fsm_d = StIdle;
        endcase

        // Outputs are registered copies of the next-state decode.
        in_ready_d  = (fsm_d == StIdle);
        out_valid_d = (fsm_d == StDone);
        busy_d      = (fsm_d == StBusy);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= StIdle;
            data_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifndef INV_MIX_COLUMNS_UNROLL_EN
            col_cnt_q   <= 2'd0;
`endif
        end else begin
            fsm_q       <= fsm_d;
            data_q      <= data_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifndef INV_MIX_COLUMNS_UNROLL_EN
            col_cnt_q   <= col_cnt_d;
`endif
        end
    end

    assign bus_io.in_ready  = in_ready_q;
    assign bus_io.out_valid = out_valid_q;
    assign bus_io.out_state = data_q;
    assign bus_io.busy      = busy_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// tb_inv_mix_columns_seq: self-checking bench for inv_mix_columns_seq.
// Reference model: general GF(2^8) multiply applied as a circulant matrix over
// each column; forward MixColumns is used to build round-trip stimulus.
module tb_inv_mix_columns_seq;

`ifdef INV_MIX_COLUMNS_UNROLL_EN
    localparam int LAT    = 1;
    localparam int PERIOD = 3;
`else
    localparam int LAT    = 4;
    localparam int PERIOD = 6;
`endif
    localparam int N_RT = 1000;

    logic clk;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    inv_mix_columns_seq_if bus ();

    inv_mix_columns_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [127:0] got,
                            input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // coef byte j multiplies row (r+j) mod 4 when producing row r.
    function automatic logic [127:0] mix(input logic [127:0] s, input logic [31:0] coef);
        logic [127:0] o;
        logic [7:0]   acc;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gmul(coef[8*j +: 8], s[32*c + 8*((r+j)%4) +: 8]);
                end
                o[32*c + 8*r +: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        return mix(s, 32'h090d0b0e);
    endfunction

    function automatic logic [127:0] fwd_mix(input logic [127:0] s);
        return mix(s, 32'h01010302);
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send_state(input string tag, input logic [127:0] din);
        int t;
        t = 0;
        while (bus.in_ready !== 1'b1 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check_eq({tag, " in_ready"}, bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_state = din;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_state = rand128();
    endtask

    task automatic wait_out(input string tag);
        int lat;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, " latency"}, lat, LAT);
    endtask

    task automatic take_out();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic run_one(input string tag, input logic [127:0] din,
                           input logic [127:0] exp);
        send_state(tag, din);
        wait_out(tag);
        check_eq({tag, " data"}, bus.out_state, exp);
        take_out();
    endtask

    initial begin
        logic [127:0] s;
        logic [127:0] held;
        logic [127:0] s_cur;
        logic [127:0] exp_q[$];
        int sent, recv, last, cyc;
        logic acc_in, acc_out;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_state  = '0;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        check_eq("rst in_ready", bus.in_ready, 1);
        check_eq("rst out_valid", bus.out_valid, 0);
        check_eq("rst busy", bus.busy, 0);
        check_eq("rst out_state", bus.out_state, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Known single column.
        run_one("known col", 128'h00000000_00000000_00000000_bca14d8e,
                128'h00000000_00000000_00000000_455313db);

        // Full known state.
        run_one("known state", 128'hc6c6c6c6_01010101_d6d7d5d5_9d58dc9f,
                128'hc6c6c6c6_01010101_d5d4d4d4_5c220af2);

        // busy visible during transformation (iterative build only lasts >1 cycle).
        send_state("busy", 128'h0);
        check_eq("busy high", bus.busy, 1);
        wait_out("busy");
        check_eq("busy low in done", bus.busy, 0);
        take_out();

        // Back-pressure: result held, new inputs ignored.
        s = rand128();
        send_state("bp", s);
        wait_out("bp");
        held = bus.out_state;
        check_eq("bp data", held, inv_mix(s));
        for (int i = 0; i < 10; i++) begin
            check_eq("bp stable", bus.out_state, inv_mix(s));
            check_eq("bp out_valid", bus.out_valid, 1);
            check_eq("bp in_ready", bus.in_ready, 0);
            bus.in_valid = i[0];
            bus.in_state = rand128();
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        take_out();
        check_eq("bp released out_valid", bus.out_valid, 0);
        check_eq("bp released in_ready", bus.in_ready, 1);

        // Random single shots against the model.
        for (int i = 0; i < 8; i++) begin
            s = rand128();
            run_one("rand", s, inv_mix(s));
        end

        // Reset mid-operation, after column 1 is written.
        send_state("mid rst", rand128());
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_eq("mid rst out_valid", bus.out_valid, 0);
        check_eq("mid rst busy", bus.busy, 0);
        check_eq("mid rst out_state", bus.out_state, 0);
        check_eq("mid rst in_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        s = rand128();
        run_one("after rst", s, inv_mix(s));

        // Streaming round trip: forward MixColumns then this block restores the state.
        sent = 0;
        recv = 0;
        last = -1;
        cyc  = 0;
        s_cur = rand128();
        bus.in_state  = fwd_mix(s_cur);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        while (recv < N_RT && cyc < N_RT * PERIOD + 200) begin
            @(negedge clk);
            acc_in  = bus.in_ready && bus.in_valid;
            acc_out = bus.out_valid && bus.out_ready;
            if (acc_out) begin
                if (exp_q.size() == 0) begin
                    check_eq("rt spurious", acc_out, 0);
                end else begin
                    check_eq("rt data", bus.out_state, exp_q.pop_front());
                end
                if (last >= 0) check_eq("rt period", cyc - last, PERIOD);
                last = cyc;
                recv++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc_in) begin
                exp_q.push_back(s_cur);
                sent++;
                if (sent < N_RT) begin
                    s_cur        = rand128();
                    bus.in_state = fwd_mix(s_cur);
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        bus.out_ready = 1'b0;
        check_eq("rt count", recv, N_RT);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
